// File: rtl/screen_select_ctrl.sv
// Click-driven screen selector: a rising click inside the current screen's hotspot
// moves to that hotspot's target screen. Clicks are locked out for HOLDOFF cycles after each move.
module screen_select_ctrl #(
    parameter int NUM_SCREENS = 3,
    parameter int SEL_W       = 2,
    parameter int HOLDOFF     = 4,
    parameter logic [NUM_SCREENS*12-1:0]    HS_X0  = {12'd0, 12'd993, 12'd452},
    parameter logic [NUM_SCREENS*12-1:0]    HS_X1  = {12'd20, 12'd1013, 12'd581},
    parameter logic [NUM_SCREENS*12-1:0]    HS_Y0  = {12'd0, 12'd10, 12'd354},
    parameter logic [NUM_SCREENS*12-1:0]    HS_Y1  = {12'd20, 12'd30, 12'd379},
    parameter logic [NUM_SCREENS*SEL_W-1:0] HS_TGT = {2'd0, 2'd2, 2'd1}
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [11:0]               xpos,
    input  logic [11:0]               ypos,
    input  logic                      ButtonLeft,
    input  logic [NUM_SCREENS*12-1:0] rgb_in,
    output logic [11:0]               xpos_out,
    output logic [11:0]               ypos_out,
    output logic [11:0]               rgb,
    output logic [SEL_W-1:0]          Screen,
    output logic                      Changed
);

    logic             btn_q;
    logic [7:0]       hold_cnt;
    logic [11:0]      x0, x1, y0, y1;
    logic [SEL_W-1:0] tgt;
    logic [SEL_W-1:0] screen_nxt;
    logic [SEL_W-1:0] rgb_idx;
    logic [11:0]      rgb_sel;
    logic             hit;
    logic             tgt_ok;
    logic             valid;

    always_comb begin
        x0      = '0;
        x1      = '0;
        y0      = '0;
        y1      = '0;
        tgt     = '0;
        rgb_sel = rgb_in[11:0];
        // Only the active screen's hotspot is decoded; an inverted range never matches.
        for (int s = 0; s < NUM_SCREENS; s++) begin
            if (Screen == SEL_W'(s)) begin
                x0  = HS_X0[s*12 +: 12];
                x1  = HS_X1[s*12 +: 12];
                y0  = HS_Y0[s*12 +: 12];
                y1  = HS_Y1[s*12 +: 12];
                tgt = HS_TGT[s*SEL_W +: SEL_W];
            end
        end
        hit        = (xpos >= x0) && (xpos <= x1) && (ypos >= y0) && (ypos <= y1);
        tgt_ok     = (int'(tgt) < NUM_SCREENS) && (tgt != Screen);
        valid      = ButtonLeft && !btn_q && hit && (hold_cnt == 8'd0) && tgt_ok;
        screen_nxt = valid ? tgt : Screen;
        // Colour follows the screen being entered so rgb and Screen switch together.
        rgb_idx    = rst ? '0 : screen_nxt;
        for (int s = 0; s < NUM_SCREENS; s++) begin
            if (rgb_idx == SEL_W'(s)) begin
                rgb_sel = rgb_in[s*12 +: 12];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            Screen   <= '0;
            Changed  <= 1'b0;
            hold_cnt <= 8'd0;
            btn_q    <= 1'b1;
        end else begin
            btn_q   <= ButtonLeft;
            Screen  <= screen_nxt;
            Changed <= valid;
            if (valid) begin
                hold_cnt <= 8'(HOLDOFF);
            end else if (hold_cnt != 8'd0) begin
                hold_cnt <= hold_cnt - 8'd1;
            end
        end
    end

    // Datapath registers: same behaviour in and out of reset.
    always_ff @(posedge clk) begin
        xpos_out <= xpos;
        ypos_out <= ypos;
        rgb      <= rgb_sel;
    end

endmodule

// File: tb/tb_screen_select_ctrl.sv
// Directed table-driven bench for screen_select_ctrl plus hand sequences for
// held button, position latency and self-target clicks.
module tb_screen_select_ctrl;

    localparam logic [11:0] COL0 = 12'hA00;
    localparam logic [11:0] COL1 = 12'h0B0;
    localparam logic [11:0] COL2 = 12'h00C;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] xpos, ypos;
    logic        ButtonLeft;
    logic [35:0] rgb_in;
    logic [11:0] xpos_out, ypos_out, rgb;
    logic [1:0]  Screen;
    logic        Changed;
    logic [11:0] xpos_out2, ypos_out2, rgb2;
    logic [1:0]  Screen2;
    logic        Changed2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    screen_select_ctrl dut (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .ButtonLeft(ButtonLeft),
        .rgb_in(rgb_in), .xpos_out(xpos_out), .ypos_out(ypos_out), .rgb(rgb),
        .Screen(Screen), .Changed(Changed)
    );

    // Screen 1 targets itself in this instance.
    screen_select_ctrl #(.HS_TGT({2'd0, 2'd1, 2'd1})) dut2 (
        .clk(clk), .rst(rst), .xpos(xpos), .ypos(ypos), .ButtonLeft(ButtonLeft),
        .rgb_in(rgb_in), .xpos_out(xpos_out2), .ypos_out(ypos_out2), .rgb(rgb2),
        .Screen(Screen2), .Changed(Changed2)
    );

    typedef struct {
        logic        r;
        logic        b;
        logic [11:0] x;
        logic [11:0] y;
        logic [1:0]  s;
        logic        c;
        logic [11:0] col;
    } vec_t;

    vec_t tbl[$];

    task automatic add(input logic r, input logic b, input int x, input int y,
                       input int s, input logic c, input logic [11:0] col);
        vec_t v;
        v.r = r; v.b = b; v.x = 12'(x); v.y = 12'(y);
        v.s = 2'(s); v.c = c; v.col = col;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    int pulses;

    initial begin
        rst = 1'b1; ButtonLeft = 1'b0; xpos = '0; ypos = '0;
        rgb_in = {COL2, COL1, COL0};

        // reset, first transition, holdoff, second transition
        add(1,0,0,0,       0,0,COL0);
        add(1,0,0,0,       0,0,COL0);
        add(0,0,500,360,   0,0,COL0);
        add(0,1,500,360,   1,1,COL1);
        add(0,0,1000,20,   1,0,COL1);
        add(0,1,1000,20,   1,0,COL1);
        add(0,0,1000,20,   1,0,COL1);
        add(0,0,1000,20,   1,0,COL1);
        add(0,1,1000,20,   2,1,COL2);
        // press during holdoff and kept held: discarded, never fires later
        add(0,1,10,10,     2,0,COL2);
        add(0,1,10,10,     2,0,COL2);
        add(0,1,10,10,     2,0,COL2);
        add(0,1,10,10,     2,0,COL2);
        add(0,1,10,10,     2,0,COL2);
        add(0,0,10,10,     2,0,COL2);
        add(0,1,10,10,     0,1,COL0);
        for (int i = 0; i < 5; i++) add(0,0,0,0, 0,0,COL0);
        // hotspot boundaries on screen 0
        add(0,1,451,360,   0,0,COL0);
        add(0,0,451,360,   0,0,COL0);
        add(0,1,582,360,   0,0,COL0);
        add(0,0,582,360,   0,0,COL0);
        add(0,1,500,380,   0,0,COL0);
        add(0,0,500,380,   0,0,COL0);
        add(0,1,452,354,   1,1,COL1);
        add(1,0,0,0,       0,0,COL0);
        add(0,0,0,0,       0,0,COL0);
        add(0,1,581,379,   1,1,COL1);
        // reset beats a valid click; button held through reset release
        add(1,0,0,0,       0,0,COL0);
        add(0,0,0,0,       0,0,COL0);
        add(1,1,500,360,   0,0,COL0);
        add(0,1,500,360,   0,0,COL0);
        add(0,1,500,360,   0,0,COL0);
        add(0,0,500,360,   0,0,COL0);
        add(0,1,500,360,   1,1,COL1);
        // reset mid-holdoff clears it
        add(1,0,500,360,   0,0,COL0);
        add(0,0,500,360,   0,0,COL0);
        add(0,1,500,360,   1,1,COL1);

        #1;
        for (int i = 0; i < tbl.size(); i++) begin
            rst = tbl[i].r; ButtonLeft = tbl[i].b; xpos = tbl[i].x; ypos = tbl[i].y;
            tick();
            chk($sformatf("row%0d_screen", i), 32'(Screen), 32'(tbl[i].s));
            chk($sformatf("row%0d_changed", i), 32'(Changed), 32'(tbl[i].c));
            chk($sformatf("row%0d_rgb", i), 32'(rgb), 32'(tbl[i].col));
            chk($sformatf("row%0d_xout", i), 32'(xpos_out), 32'(tbl[i].x));
            chk($sformatf("row%0d_yout", i), 32'(ypos_out), 32'(tbl[i].y));
        end

        // held button: one pulse only
        rst = 1'b1; ButtonLeft = 1'b0; tick();
        rst = 1'b0; tick();
        ButtonLeft = 1'b1; xpos = 12'd500; ypos = 12'd360;
        pulses = 0;
        repeat (20) begin
            tick();
            pulses += int'(Changed);
        end
        chk("held_pulses", 32'(pulses), 32'd1);
        chk("held_screen", 32'(Screen), 32'd1);

        // position latency ramp
        ButtonLeft = 1'b0;
        for (int i = 0; i < 16; i++) begin
            xpos = 12'(i);
            tick();
            chk($sformatf("ramp%0d", i), 32'(xpos_out), 32'(i));
        end

        // self-target click on screen 1 of dut2
        rst = 1'b1; ButtonLeft = 1'b0; tick();
        rst = 1'b0; tick();
        ButtonLeft = 1'b1; xpos = 12'd500; ypos = 12'd360; tick();
        chk("self_enter_screen", 32'(Screen2), 32'd1);
        ButtonLeft = 1'b0;
        repeat (5) tick();
        ButtonLeft = 1'b1; xpos = 12'd1000; ypos = 12'd20; tick();
        chk("self_screen", 32'(Screen2), 32'd1);
        chk("self_changed", 32'(Changed2), 32'd0);
        chk("self_holdoff", 32'(dut2.hold_cnt), 32'd0);
        chk("other_screen", 32'(Screen), 32'd2);
        chk("other_changed", 32'(Changed), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/screen_select_ctrl.md
SCREEN_SELECT_CTRL -- requirements
Module: screen_select_ctrl

Interface
REQ-001 The parameters SHALL be as follows; all packed vectors place screen 0 in the LSBs.
- NUM_SCREENS, default 3: number of screens, legal range 2..8.
- SEL_W, default 2: screen index width, equal to clog2(NUM_SCREENS), minimum 1.
- HOLDOFF, default 4: cycles after a transition during which clicks are ignored, 0..255.
- HS_X0, default {12'd0, 12'd993, 12'd452}: per-screen hotspot left bound, NUM_SCREENS*12 bits.
- HS_X1, default {12'd20, 12'd1013, 12'd581}: per-screen hotspot right bound.
- HS_Y0, default {12'd0, 12'd10, 12'd354}: per-screen hotspot top bound.
- HS_Y1, default {12'd20, 12'd30, 12'd379}: per-screen hotspot bottom bound.
- HS_TGT, default {2'd0, 2'd2, 2'd1}: per-screen target screen, NUM_SCREENS*SEL_W bits.

REQ-002 The ports SHALL be as follows.
- clk, in, 1: single clock; all logic on the rising edge.
- rst, in, 1: synchronous, active-high reset.
- xpos, in, 12: pointer x.
- ypos, in, 12: pointer y.
- ButtonLeft, in, 1: left mouse button level, already synchronous to clk.
- rgb_in, in, NUM_SCREENS*12: per-screen pixel colour, screen 0 in the LSBs.
- xpos_out, out, 12: xpos delayed one cycle.
- ypos_out, out, 12: ypos delayed one cycle.
- rgb, out, 12: registered colour of the active screen.
- Screen, out, SEL_W: active screen index.
- Changed, out, 1: one-cycle pulse on each screen transition.

Function
REQ-003 The block SHALL register ButtonLeft into btn_q every cycle, and a click edge SHALL be ButtonLeft=1 with btn_q=0.
REQ-004 A hit SHALL be xpos in [HS_X0[s], HS_X1[s]] and ypos in [HS_Y0[s], HS_Y1[s]], both inclusive, where s is the current Screen.
REQ-005 A hotspot with X0>X1 or Y0>Y1 SHALL never hit, which disables that screen's hotspot.
REQ-006 A valid click SHALL be click edge AND hit AND holdoff counter = 0 AND HS_TGT[s] < NUM_SCREENS AND HS_TGT[s] != s.
REQ-007 A valid click sampled on edge t SHALL cause, at edge t: Screen <= HS_TGT[s], Changed <= 1, holdoff counter <= HOLDOFF.
REQ-008 When there is no valid click, Screen SHALL hold and Changed SHALL be 0 at that edge.
REQ-009 The holdoff counter SHALL decrement by 1 per cycle while non-zero and saturate at 0.
REQ-010 With HOLDOFF=0, clicks on consecutive edges SHALL each be eligible.
REQ-011 A button held high SHALL produce exactly one click edge; a new transition requires release and re-press.
REQ-012 A click edge arriving during holdoff SHALL be discarded, not queued, and SHALL NOT fire when holdoff expires.
REQ-013 rgb SHALL be registered from the rgb_in slice indexed by the next value of Screen.
REQ-014 rgb SHALL therefore show the new screen's colour on the same edge at which Screen changes, one cycle after xpos/ypos/rgb_in are sampled.
REQ-015 xpos_out and ypos_out SHALL be xpos and ypos registered with one-cycle latency, so position stays aligned with rgb.
REQ-016 Only the current screen's hotspot SHALL be evaluated; hotspots of other screens have no effect.
REQ-017 No combinational path SHALL exist from any input to any output.

Reset
REQ-018 While rst=1 at an edge: Screen <= 0, Changed <= 0, holdoff <= 0, btn_q <= 1, rgb <= rgb_in[11:0], xpos_out <= xpos, ypos_out <= ypos.
REQ-019 Because btn_q resets to 1, a button held through reset release SHALL NOT produce a click.
REQ-020 Reset asserted mid-holdoff or in the same cycle as a valid click SHALL take priority: Screen=0, Changed=0, no transition.

Verification
REQ-021 Basic transition (defaults): Screen=0, pointer (500,360), ButtonLeft 0->1 -> next edge Screen=1, Changed=1 for one cycle, rgb=rgb_in[23:12].
REQ-022 Holdoff: after REQ-021, re-press at (1000,20) within 4 cycles -> Screen stays 1, Changed=0. Re-press after 4 cycles -> Screen=2, rgb=rgb_in[35:24].
REQ-023 Boundaries: clicks at (452,354) and (581,379) hit on screen 0. Clicks at (451,360), (582,360) and (500,380) leave Screen=0.
REQ-024 Held button: ButtonLeft held high for 20 cycles inside the screen-0 hotspot -> exactly one Changed pulse, Screen=1.
REQ-025 Reset: ButtonLeft=1 at (500,360) through rst 1->0 -> Screen=0, Changed=0, no transition until release and re-press.
REQ-026 Latency: ramp xpos 0..15, one value per cycle -> xpos_out equals xpos of the previous cycle. A self-target (HS_TGT[s]=s) click -> Changed=0 and holdoff not loaded.
